// File: rtl/clock_div_pkg.sv
// Shared definitions for the clock_div_ctrl slice.
//   - Controller state encodings (legacy 2-bit values kept for compatibility).
//   - Width and saturation value of the optional period counter
//     (present when CLOCK_DIV_CTRL_PERIOD_CNT_EN is defined).
package clock_div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t PEND = 2'd2;

    localparam int                      PERIOD_CNT_W   = 16;
    localparam logic [PERIOD_CNT_W-1:0] PERIOD_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/clock_div_ctrl_if.sv
// Configuration port of clock_div_ctrl: a valid/ready ratio offer.
//   cfg_valid  master -> slave  new ratio offered
//   cfg_div    master -> slave  offered divide ratio (CNT_WIDTH bits)
//   cfg_ready  slave -> master  controller can accept a ratio
interface clock_div_ctrl_if #(
    parameter int CNT_WIDTH = 4
) ();

    logic                 cfg_valid;
    logic [CNT_WIDTH-1:0] cfg_div;
    logic                 cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clock_div_ctrl_counter.sv
// div_counter_nbit: CNT_WIDTH-bit wrap counter used by clock_div_ctrl.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (count -> 0)
//   clr_i    synchronous clear, has priority over en_i
//   en_i     advance the counter this cycle
//   ratio_i  divide ratio; 0 and 1 both mean divide-by-1
//   count_o  current count, never exceeds ratio-1
//   wrap_o   combinational: count is at the last value of the period
module div_counter_nbit #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] ratio_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 wrap_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Ratios 0 and 1 wrap every cycle; the subtraction result is only used
    // when ratio_i >= 2, so its underflow for 0 is harmless.
    always_comb begin
        wrap_o = (ratio_i <= ONE) || (count_q == (ratio_i - ONE));
    end

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap_o ? '0 : (count_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: controller/sequencer for a programmable clock-enable divider.
// New ratios arrive over a valid/ready port and are applied only at a period
// boundary, so a running period is never truncated.
//   clk         rising-edge system clock
//   reset_n     asynchronous active-low reset
//   enable      level-sensitive run request
//   cfg         clock_div_ctrl_if.slave (cfg_valid, cfg_div, cfg_ready)
//   tick        one-cycle pulse, once per divide period
//   div_out     toggles on every tick (period 2*ratio clocks)
//   busy        controller is not IDLE
//   counter     current count value
//   period_cnt  (only with CLOCK_DIV_CTRL_PERIOD_CNT_EN) saturating tick count,
//               cleared whenever the active ratio is written
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int CNT_WIDTH   = 4,
    parameter int DIV_DEFAULT = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    clock_div_ctrl_if.slave      cfg,
    output logic                 tick,
    output logic                 div_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] counter
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] div_reg_q;
    logic [CNT_WIDTH-1:0] div_reg_d;
    logic [CNT_WIDTH-1:0] pend_div_q;
    logic [CNT_WIDTH-1:0] pend_div_d;
    logic                 tick_q;
    logic                 tick_d;
    logic                 div_out_q;
    logic                 div_out_d;

    logic                 accept;
    logic                 div_wr;
    logic                 cnt_clr;
    logic                 cnt_wrap;

    assign cfg.cfg_ready = (state_q != PEND);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    // The counter sits at 0 whenever the controller is (or is about to be) idle.
    assign cnt_clr = (state_q == IDLE) || !enable;

    div_counter_nbit #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr_i   (cnt_clr),
        .en_i    (!cnt_clr),
        .ratio_i (div_reg_q),
        .count_o (counter),
        .wrap_o  (cnt_wrap)
    );

    always_comb begin
        state_d    = state_q;
        div_reg_d  = div_reg_q;
        pend_div_d = pend_div_q;
        tick_d     = 1'b0;
        div_out_d  = div_out_q;
        div_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    div_reg_d = cfg.cfg_div;
                    div_wr    = 1'b1;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!enable) begin
                    // A ratio accepted while stopping goes straight to the
                    // active register, as it would in IDLE.
                    if (accept) begin
                        div_reg_d = cfg.cfg_div;
                        div_wr    = 1'b1;
                    end
                    div_out_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    if (cnt_wrap) begin
                        tick_d    = 1'b1;
                        div_out_d = ~div_out_q;
                    end
                    // Accept on a wrap edge still parks the ratio, so it
                    // applies at the following wrap, not this one.
                    if (accept) begin
                        pend_div_d = cfg.cfg_div;
                        state_d    = PEND;
                    end
                end
            end

            PEND: begin
                if (!enable) begin
                    div_reg_d = pend_div_q;
                    div_wr    = 1'b1;
                    div_out_d = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_wrap) begin
                    tick_d    = 1'b1;
                    div_out_d = ~div_out_q;
                    div_reg_d = pend_div_q;
                    div_wr    = 1'b1;
                    state_d   = RUN;
                end
            end

            default: begin
                state_d   = IDLE;
                div_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_reg_q  <= CNT_WIDTH'(DIV_DEFAULT);
            pend_div_q <= '0;
            tick_q     <= 1'b0;
            div_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_reg_q  <= div_reg_d;
            pend_div_q <= pend_div_d;
            tick_q     <= tick_d;
            div_out_q  <= div_out_d;
        end
    end

    assign tick    = tick_q;
    assign div_out = div_out_q;
    assign busy    = (state_q != IDLE);

`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] period_cnt_q;
    logic [PERIOD_CNT_W-1:0] period_cnt_d;

    // A ratio write wins over a coincident tick: the count restarts at 0.
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (div_wr) begin
            period_cnt_d = '0;
        end else if (tick_d && (period_cnt_q != PERIOD_CNT_MAX)) begin
            period_cnt_d = period_cnt_q + PERIOD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`else
    logic unused_div_wr;
    assign unused_div_wr = div_wr;
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Scoreboard bench for clock_div_ctrl: directed scenarios followed by random
// traffic, checked against a period/position model of the divider.
module tb_clock_div_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         tick;
    logic         div_out;
    logic         busy;
    logic [W-1:0] counter;
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0]  period_cnt;
`endif

    clock_div_ctrl_if #(.CNT_WIDTH(W)) cfg_if ();

    clock_div_ctrl #(
        .CNT_WIDTH   (W),
        .DIV_DEFAULT (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .cfg     (cfg_if),
        .tick    (tick),
        .div_out (div_out),
        .busy    (busy),
        .counter (counter)
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc_n, act, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int tick;
        int dout;
        int busy;
        int rdy;
        int cnt;
        int pcnt;
    } exp_t;

    exp_t sb[$];

    // Model: running/pending flags, active and parked ratio, position in period.
    int m_run, m_pend, m_ratio, m_pratio, m_pos, m_div, m_tick, m_pcnt;

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_ratio = 2; m_pratio = 0;
        m_pos = 0; m_div = 0; m_tick = 0; m_pcnt = 0;
    endfunction

    function automatic int period_len(input int r);
        return (r < 2) ? 1 : r;
    endfunction

    function automatic void model_step(input int en, input int v, input int d);
        int accept;
        int wrapped;
        accept = (v != 0) && (m_pend == 0);
        if (m_run == 0) begin
            if (accept) begin m_ratio = d; m_pcnt = 0; end
            if (en) m_run = 1;
            m_pos = 0;
            m_tick = 0;
        end else if (en == 0) begin
            if (m_pend) begin m_ratio = m_pratio; m_pend = 0; m_pcnt = 0; end
            else if (accept) begin m_ratio = d; m_pcnt = 0; end
            m_run = 0; m_pos = 0; m_tick = 0; m_div = 0;
        end else begin
            m_pos   = (m_pos + 1) % period_len(m_ratio);
            wrapped = (m_pos == 0);
            m_tick  = wrapped;
            if (wrapped) begin
                m_div = 1 - m_div;
                if (m_pcnt < 65535) m_pcnt++;
            end
            if (m_pend && wrapped) begin
                m_ratio = m_pratio; m_pend = 0; m_pcnt = 0;
            end else if (accept) begin
                m_pratio = d; m_pend = 1;
            end
        end
    endfunction

    // One clock of stimulus; the expectation targets the next rising edge.
    task automatic cycle(input int en, input int v, input int d);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        enable = en[0];
        cfg_if.cfg_valid = v[0];
        cfg_if.cfg_div = W'(d);
        model_step(en, v, d);
        e.cyc = cyc_n + 1;
        e.tick = m_tick; e.dout = m_div; e.busy = m_run;
        e.rdy = (m_pend == 0); e.cnt = m_pos; e.pcnt = m_pcnt;
        sb.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_div_out"}, int'(div_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_if.cfg_ready), 1);
        chk({tag, "_counter"}, int'(counter), 0);
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
        chk({tag, "_period_cnt"}, int'(period_cnt), 0);
`endif
    endtask

    // Asserted between edges; outputs must fall back without waiting for a clock.
    task automatic pulse_reset();
        @(posedge clk);
        #6;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        sb.delete();
        model_reset();
    endtask

    // Monitor: compares every cycle for which an expectation was queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
                e = sb.pop_front();
                if (e.cyc != cyc_n) chk("sb_cycle", e.cyc, cyc_n);
                chk("tick", int'(tick), e.tick);
                chk("div_out", int'(div_out), e.dout);
                chk("busy", int'(busy), e.busy);
                chk("cfg_ready", int'(cfg_if.cfg_ready), e.rdy);
                chk("counter", int'(counter), e.cnt);
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
                chk("period_cnt", int'(period_cnt), e.pcnt);
`endif
            end
        end
    end

    initial begin
        int guard;
        reset_n = 1'b0;
        enable = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div = '0;
        model_reset();
        #2;
        check_reset_values("reset");

        // Default ratio 2.
        repeat (10) cycle(1, 0, 0);

        // Ratio 5 written in IDLE.
        repeat (2) cycle(0, 0, 0);
        cycle(0, 1, 5);
        repeat (14) cycle(1, 0, 0);

        // Ratio 3 running, 6 offered mid-period.
        cycle(0, 0, 0);
        cycle(0, 1, 3);
        repeat (4) cycle(1, 0, 0);
        cycle(1, 1, 6);
        repeat (20) cycle(1, 0, 0);

        // Ratio 2, 4 offered exactly on a wrap edge.
        cycle(0, 0, 0);
        cycle(0, 1, 2);
        repeat (3) cycle(1, 0, 0);
        guard = 0;
        while (m_pos != period_len(m_ratio) - 1 && guard < 20) begin
            cycle(1, 0, 0);
            guard++;
        end
        cycle(1, 1, 4);
        repeat (14) cycle(1, 0, 0);

        // Divide-by-1 via ratio 0 and ratio 1.
        for (int r = 0; r < 2; r++) begin
            cycle(0, 0, 0);
            cycle(0, 1, r);
            repeat (6) cycle(1, 0, 0);
        end

        // Disable while holding pending 7, re-enable, then reset mid-run.
        cycle(0, 0, 0);
        cycle(0, 1, 3);
        repeat (2) cycle(1, 0, 0);
        cycle(1, 1, 7);
        cycle(0, 0, 0);
        repeat (16) cycle(1, 0, 0);
        pulse_reset();
        repeat (6) cycle(1, 0, 0);

        // Random traffic, occasional asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 120) == 0) begin
                pulse_reset();
            end else begin
                cycle(($urandom_range(0, 9) != 0) ? 1 : 0,
                      ($urandom_range(0, 3) == 0) ? 1 : 0,
                      int'($urandom_range(0, 15)));
            end
        end

        repeat (3) @(posedge clk);
        #6;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Controller and sequencer for a programmable clock-enable divider.
- Owns a wrap counter and the active divide ratio.
- Accepts new ratios through a valid/ready config port and applies them only at a period boundary, so no period is ever truncated.
- Drives a single-cycle tick enable and a toggling divided output for downstream logic in the same clock domain.

Parameters:
- CNT_WIDTH, 4, width of the counter, the divide ratio and cfg_div.
- DIV_DEFAULT, 2, divide ratio loaded at reset; must be in 1..2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  run request; level-sensitive.
- cfg_valid  input  1  new ratio offered.
- cfg_div  input  CNT_WIDTH  offered divide ratio.
- cfg_ready  output  1  controller can accept a ratio.
- tick  output  1  one-cycle pulse, once per divide period.
- div_out  output  1  toggles on every tick; period is 2*ratio clocks.
- busy  output  1  high when state is not IDLE.
- counter  output  CNT_WIDTH  current count value.

Behaviour:
- Reset values (asynchronous, on reset_n low):
  - state=IDLE, counter=0, div_reg=DIV_DEFAULT, pend_div=0.
  - tick=0, div_out=0, cfg_ready=1, busy=0.
- Ratio rule: an effective ratio r of 0 or 1 both mean divide-by-1, i.e. the counter stays 0 and tick is high every cycle while running.
- Wrap condition: counter == r-1.
- States:
  - IDLE: counter held at 0, tick=0, cfg_ready=1. A config accept writes div_reg directly and stays in IDLE. enable=1 moves to RUN on the next edge with counter=0.
  - RUN: counter increments every cycle. At the wrap edge: counter<=0, tick<=1, div_out<=~div_out; on all other edges tick<=0. A config accept (cfg_valid & cfg_ready) captures cfg_div into pend_div and moves to PEND.
  - PEND: cfg_ready=0 and counting continues with the old div_reg. At the next wrap edge: normal wrap actions plus div_reg<=pend_div, then back to RUN.
- Accept on a wrap edge: an accept in RUN on the same edge as a wrap still goes to PEND. The new ratio applies at the following wrap, never at the current one.
- enable deasserted in RUN or PEND:
  - Next edge goes to IDLE: counter<=0, tick<=0, div_out<=0.
  - From PEND, pend_div is copied into div_reg so the accepted value is never lost.
- enable is ignored while in IDLE with enable=0; cfg is ignored while cfg_ready=0.
- Registered outputs:
  - tick, div_out and counter are registers.
  - cfg_ready = (state != PEND), combinational from state.
  - busy = (state != IDLE).
- Counter arithmetic: counter is CNT_WIDTH bits and never exceeds r-1, so it cannot overflow.
- Reset mid-operation: an asynchronous return to the reset values; any pending ratio is discarded.

Optional Feature:
- Macro: CLOCK_DIV_CTRL_PERIOD_CNT_EN.
- When defined:
  - Adds output period_cnt[15:0], which increments on every tick and saturates at 16'hFFFF.
  - period_cnt is cleared by reset and on any edge that writes div_reg.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package / include file clock_div_pkg holds:
  - State encodings IDLE=2'd0, RUN=2'd1, PEND=2'd2.
  - The period counter width (16) and its saturation value.
- One sub-module, div_counter_nbit: a CNT_WIDTH wrap counter with a clear input, an enable input, a ratio input and a wrap output.
- The controller FSM, the div_reg/pend_div registers and the output registers stay in clock_div_ctrl.

Test Plan:
- Reset, then enable=1 with DIV_DEFAULT=2 -> tick high every 2nd cycle; div_out period is 4 clocks; counter sequence 0,1,0,1.
- In IDLE, write cfg_div=5, then enable -> first tick 5 cycles after counter leaves 0; busy=1; cfg_ready=1.
- In RUN with ratio 3, write cfg_div=6 mid-period -> cfg_ready drops, the current period completes at 3, all later periods are 6, cfg_ready returns high after the wrap.
- Accept cfg_div=4 on the same edge as a wrap with ratio 2 -> one more period of 2, then periods of 4.
- cfg_div=0 and, separately, cfg_div=1 -> tick high continuously, counter stuck at 0, div_out toggles every cycle.
- Drop enable in PEND holding pend_div=7, then re-enable -> tick period 7; reset_n pulsed mid-RUN -> all outputs return to reset values immediately, asynchronously.
